// File: rtl/pipe_port_alloc.sv
`default_nettype none
// ============================================================================
// Module   : pipe_port_alloc
// Purpose  : Two-stage pipelined output-port allocator with deflection.
//            Channels are served in rank order (channel 0 first). Stage 1
//            allocates channels 0..SPLIT-1 from avail_in. Stage 2 allocates
//            the remaining channels from the residual free-port vector that
//            stage 1 left behind. A channel gets its lowest free productive
//            port. If no productive port is free, it is deflected to some
//            other free port, or it gets no port when none are left.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            in_valid       - an allocation set is presented this cycle
//            ch_valid[C]    - per-channel flit present
//            ppv[C*P]       - productive port vector, channel c at [c*P +: P]
//            avail_in[P]    - output ports free for this set
//            clr_count      - clears defl_count (wins over increment)
//            out_valid      - result set valid (two cycles after input)
//            alloc[C*P]     - one-hot or zero grant per channel
//            deflected[C]   - channel granted a non-productive port
//            no_port[C]     - channel valid but no port left
//            defl_count     - saturating deflection total
// Revision : 1.0 - initial release
// ============================================================================
module pipe_port_alloc #(
  parameter int NUM_PORT   = 5,
  parameter int NUM_CH     = 4,
  parameter int SPLIT      = 2,
  parameter int RR_DEFLECT = 1,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH*NUM_PORT-1:0] ppv,
  input  logic [NUM_PORT-1:0]        avail_in,
  input  logic                       clr_count,
  output logic                       out_valid,
  output logic [NUM_CH*NUM_PORT-1:0] alloc,
  output logic [NUM_CH-1:0]          deflected,
  output logic [NUM_CH-1:0]          no_port,
  output logic [CNT_W-1:0]           defl_count
);

  localparam int PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int HI_CH = NUM_CH - SPLIT;
  localparam int POP_W = $clog2(NUM_CH + 1);

  // --------------------------------------------------------------------------
  // Selection helpers
  // --------------------------------------------------------------------------
  function automatic logic [NUM_PORT-1:0] lowest_bit(input logic [NUM_PORT-1:0] v);
    logic [NUM_PORT-1:0] r;
    logic                found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // First set bit at index ptr or above, wrapping around to index 0.
  function automatic logic [NUM_PORT-1:0] rr_pick(input logic [NUM_PORT-1:0] v,
                                                  input logic [PTR_W-1:0]    ptr);
    logic [NUM_PORT-1:0] r;
    logic                found;
    int                  idx;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORT; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_PORT) idx = idx - NUM_PORT;
      if (v[idx] && !found) begin
        r[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return r;
  endfunction

  // Productive grant if possible, otherwise a deflection port; zero if a==0.
  function automatic logic [NUM_PORT-1:0] pick_grant(input logic [NUM_PORT-1:0] p,
                                                     input logic [NUM_PORT-1:0] a,
                                                     input logic [PTR_W-1:0]    ptr);
    logic [NUM_PORT-1:0] r;
    if ((p & a) != '0)       r = lowest_bit(p & a);
    else if (RR_DEFLECT != 0) r = rr_pick(a, ptr);
    else                      r = lowest_bit(a);
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]          rr_ptr;

  logic                      s1_valid;
  logic [SPLIT*NUM_PORT-1:0] s1_grant;
  logic [SPLIT-1:0]          s1_defl;
  logic [SPLIT-1:0]          s1_nop;
  logic [NUM_PORT-1:0]       s1_avail;
  logic [HI_CH*NUM_PORT-1:0] s1_ppv;
  logic [HI_CH-1:0]          s1_chv;

  // --------------------------------------------------------------------------
  // Stage 1: channels 0..SPLIT-1 from avail_in
  // --------------------------------------------------------------------------
  logic [SPLIT*NUM_PORT-1:0] s1_grant_d;
  logic [SPLIT-1:0]          s1_defl_d;
  logic [SPLIT-1:0]          s1_nop_d;
  logic [NUM_PORT-1:0]       s1_a;

  always_comb begin
    logic [NUM_PORT-1:0] p;
    logic [NUM_PORT-1:0] g;
    p          = '0;
    g          = '0;
    s1_a       = avail_in;
    s1_grant_d = '0;
    s1_defl_d  = '0;
    s1_nop_d   = '0;
    for (int c = 0; c < SPLIT; c++) begin
      if (in_valid && ch_valid[c]) begin
        p = ppv[c*NUM_PORT +: NUM_PORT];
        g = pick_grant(p, s1_a, rr_ptr);
        s1_grant_d[c*NUM_PORT +: NUM_PORT] = g;
        s1_defl_d[c] = ((p & s1_a) == '0) && (s1_a != '0);
        s1_nop_d[c]  = (s1_a == '0);
        s1_a         = s1_a & ~g;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: channels SPLIT..NUM_CH-1 from the residual free vector
  // --------------------------------------------------------------------------
  logic [HI_CH*NUM_PORT-1:0] s2_grant;
  logic [HI_CH-1:0]          s2_defl;
  logic [HI_CH-1:0]          s2_nop;

  always_comb begin
    logic [NUM_PORT-1:0] a;
    logic [NUM_PORT-1:0] p;
    logic [NUM_PORT-1:0] g;
    a        = s1_avail;
    p        = '0;
    g        = '0;
    s2_grant = '0;
    s2_defl  = '0;
    s2_nop   = '0;
    for (int c = 0; c < HI_CH; c++) begin
      if (s1_valid && s1_chv[c]) begin
        p = s1_ppv[c*NUM_PORT +: NUM_PORT];
        g = pick_grant(p, a, rr_ptr);
        s2_grant[c*NUM_PORT +: NUM_PORT] = g;
        s2_defl[c] = ((p & a) == '0) && (a != '0);
        s2_nop[c]  = (a == '0);
        a          = a & ~g;
      end
    end
  end

  // Stage-1 results are already zero for an invalid set, so concatenation
  // yields an all-zero word whenever out_valid will be 0.
  logic [NUM_CH*NUM_PORT-1:0] alloc_d;
  logic [NUM_CH-1:0]          defl_d;
  logic [NUM_CH-1:0]          nop_d;

  assign alloc_d = {s2_grant, s1_grant};
  assign defl_d  = {s2_defl, s1_defl};
  assign nop_d   = {s2_nop, s1_nop};

  // --------------------------------------------------------------------------
  // Deflection counter and shared round-robin pointer
  // --------------------------------------------------------------------------
  logic [POP_W-1:0] pop;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;
  logic             any_defl;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop = pop + POP_W'(defl_d[c]);
    end
    cnt_sum = {1'b0, defl_count} + (CNT_W+1)'(pop);
    if (clr_count)            cnt_next = '0;
    else if (cnt_sum[CNT_W])  cnt_next = '1;
    else                      cnt_next = cnt_sum[CNT_W-1:0];
  end

  // One step per edge even when both stages deflect in the same cycle.
  assign any_defl = (|s1_defl_d) || (|s2_defl);

  always_comb begin
    if (RR_DEFLECT == 0)                       ptr_next = '0;
    else if (!any_defl)                        ptr_next = rr_ptr;
    else if (rr_ptr == PTR_W'(NUM_PORT - 1))   ptr_next = '0;
    else                                       ptr_next = rr_ptr + PTR_W'(1);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_grant   <= '0;
      s1_defl    <= '0;
      s1_nop     <= '0;
      s1_avail   <= '0;
      s1_ppv     <= '0;
      s1_chv     <= '0;
      out_valid  <= 1'b0;
      alloc      <= '0;
      deflected  <= '0;
      no_port    <= '0;
      defl_count <= '0;
      rr_ptr     <= '0;
    end else begin
      s1_valid   <= in_valid;
      s1_grant   <= s1_grant_d;
      s1_defl    <= s1_defl_d;
      s1_nop     <= s1_nop_d;
      s1_avail   <= s1_a;
      s1_ppv     <= ppv[NUM_CH*NUM_PORT-1:SPLIT*NUM_PORT];
      s1_chv     <= ch_valid[NUM_CH-1:SPLIT];
      out_valid  <= s1_valid;
      alloc      <= alloc_d;
      deflected  <= defl_d;
      no_port    <= nop_d;
      defl_count <= cnt_next;
      rr_ptr     <= ptr_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_port_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_port_alloc
// Purpose  : Directed self-checking bench. Two allocators share one stimulus
//            stream: u_lin (lowest-index deflection, 4-bit counter) and
//            u_rr (round-robin deflection, 16-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_port_alloc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  ch_valid;
  logic [19:0] ppv;
  logic [4:0]  avail_in;
  logic        clr_count;

  logic        l_ov, r_ov;
  logic [19:0] l_alloc, r_alloc;
  logic [3:0]  l_defl, r_defl, l_nop, r_nop;
  logic [3:0]  l_cnt;
  logic [15:0] r_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_port_alloc #(.NUM_PORT(5), .NUM_CH(4), .SPLIT(2), .RR_DEFLECT(0), .CNT_W(4)) u_lin (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ch_valid(ch_valid), .ppv(ppv),
    .avail_in(avail_in), .clr_count(clr_count), .out_valid(l_ov), .alloc(l_alloc),
    .deflected(l_defl), .no_port(l_nop), .defl_count(l_cnt)
  );

  pipe_port_alloc #(.NUM_PORT(5), .NUM_CH(4), .SPLIT(2), .RR_DEFLECT(1), .CNT_W(16)) u_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ch_valid(ch_valid), .ppv(ppv),
    .avail_in(avail_in), .clr_count(clr_count), .out_valid(r_ov), .alloc(r_alloc),
    .deflected(r_defl), .no_port(r_nop), .defl_count(r_cnt)
  );

  function automatic logic [19:0] pv(input logic [4:0] c3, input logic [4:0] c2,
                                     input logic [4:0] c1, input logic [4:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] cv, input logic [19:0] p,
                       input logic [4:0] av);
    in_valid = v;
    ch_valid = cv;
    ppv      = p;
    avail_in = av;
  endtask

  initial begin
    reset = 1'b1; clr_count = 1'b0;
    drive(1'b0, 4'b0, 20'b0, 5'b0);
    tick; tick;
    check("rst_out_valid", l_ov, 0);
    check("rst_alloc", l_alloc, 0);
    check("rst_flags", {l_defl, l_nop}, 0);
    check("rst_cnt", l_cnt, 0);
    check("rst_rr_ptr", u_rr.rr_ptr, 0);
    reset = 1'b0;

    // Productive and deflected grants spanning both stages
    drive(1'b1, 4'b1111, pv(5'b00100, 5'b00100, 5'b00001, 5'b00001), 5'b11111);
    tick;
    check("t1_no_early_out", l_ov, 0);
    check("t1_ptr_after_s1", u_rr.rr_ptr, 1);
    in_valid = 1'b0;
    tick;
    check("t1_out_valid", l_ov, 1);
    check("t1_lin_alloc", l_alloc, pv(5'b01000, 5'b00100, 5'b00010, 5'b00001));
    check("t1_lin_defl", l_defl, 4'b1010);
    check("t1_lin_nop", l_nop, 4'b0000);
    check("t1_lin_cnt", l_cnt, 2);
    check("t1_rr_alloc", r_alloc, pv(5'b01000, 5'b00100, 5'b00010, 5'b00001));
    check("t1_rr_defl", r_defl, 4'b1010);
    check("t1_rr_ptr", u_rr.rr_ptr, 2);
    check("t1_lin_ptr_hold", u_lin.rr_ptr, 0);
    tick;
    check("t1_drain_valid", l_ov, 0);
    check("t1_drain_zero", {l_alloc, l_defl, l_nop}, 0);

    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rst2_rr_cnt", r_cnt, 0);
    check("rst2_rr_ptr", u_rr.rr_ptr, 0);

    // Round-robin deflection, same set presented twice
    drive(1'b1, 4'b0011, pv(5'b0, 5'b0, 5'b00010, 5'b00010), 5'b11111);
    tick;
    check("rr_ptr_first", u_rr.rr_ptr, 1);
    tick;
    in_valid = 1'b0;
    check("rr_set1_alloc", r_alloc, pv(5'b0, 5'b0, 5'b00001, 5'b00010));
    check("rr_ptr_second", u_rr.rr_ptr, 2);
    tick;
    check("rr_set2_alloc", r_alloc, pv(5'b0, 5'b0, 5'b00100, 5'b00010));
    check("rr_set2_defl", r_defl, 4'b0010);
    check("rr_lin_alloc", l_alloc, pv(5'b0, 5'b0, 5'b00001, 5'b00010));
    check("rr_lin_cnt", l_cnt, 2);
    check("rr_rr_cnt", r_cnt, 2);

    // Exhaustion: two free ports, four channels
    drive(1'b1, 4'b1111, pv(5'b10000, 5'b10000, 5'b10000, 5'b10000), 5'b00011);
    tick;
    in_valid = 1'b0;
    tick;
    check("ex_lin_alloc", l_alloc, pv(5'b0, 5'b0, 5'b00010, 5'b00001));
    check("ex_lin_defl", l_defl, 4'b0011);
    check("ex_lin_nop", l_nop, 4'b1100);
    check("ex_rr_alloc", r_alloc, pv(5'b0, 5'b0, 5'b00010, 5'b00001));
    check("ex_rr_nop", r_nop, 4'b1100);
    check("ex_rr_ptr", u_rr.rr_ptr, 3);
    check("ex_lin_cnt", l_cnt, 4);

    // Throughput with a gap: sets in cycles 0, 1 and 3
    drive(1'b1, 4'b1111, pv(5'b01000, 5'b00100, 5'b00010, 5'b00001), 5'b11111);
    tick;
    drive(1'b1, 4'b0100, pv(5'b0, 5'b10000, 5'b0, 5'b0), 5'b11111);
    tick;
    check("tp_c2_valid", l_ov, 1);
    check("tp_c2_alloc", l_alloc, pv(5'b01000, 5'b00100, 5'b00010, 5'b00001));
    in_valid = 1'b0;
    tick;
    check("tp_c3_valid", l_ov, 1);
    check("tp_c3_alloc", l_alloc, pv(5'b0, 5'b10000, 5'b0, 5'b0));
    drive(1'b1, 4'b1001, pv(5'b00010, 5'b0, 5'b0, 5'b00100), 5'b11111);
    tick;
    check("tp_c4_valid", l_ov, 0);
    check("tp_c4_alloc", l_alloc, 0);
    in_valid = 1'b0;
    tick;
    check("tp_c5_valid", l_ov, 1);
    check("tp_c5_alloc", l_alloc, pv(5'b00010, 5'b0, 5'b0, 5'b00100));
    tick;
    check("tp_c6_valid", l_ov, 0);
    check("tp_cnt_hold", l_cnt, 4);

    // Saturation: zero ppv forces deflection on every channel
    drive(1'b1, 4'b1111, 20'b0, 5'b11111);
    tick;
    tick;
    check("sat_zero_ppv_alloc", l_alloc, pv(5'b01000, 5'b00100, 5'b00010, 5'b00001));
    check("sat_zero_ppv_defl", l_defl, 4'b1111);
    check("sat_cnt_8", l_cnt, 8);
    tick;
    check("sat_cnt_12", l_cnt, 12);
    drive(1'b1, 4'b0001, 20'b0, 5'b11111);
    tick;
    in_valid = 1'b0;
    check("sat_cnt_clamp", l_cnt, 15);
    tick;
    check("sat_last_defl", l_defl, 4'b0001);
    check("sat_cnt_stays", l_cnt, 15);
    check("sat_rr_cnt", r_cnt, 17);

    // Clear coincident with a deflected output
    drive(1'b1, 4'b0001, 20'b0, 5'b11111);
    tick;
    in_valid  = 1'b0;
    clr_count = 1'b1;
    tick;
    clr_count = 1'b0;
    check("clr_defl_seen", l_defl, 4'b0001);
    check("clr_lin_cnt", l_cnt, 0);
    check("clr_rr_cnt", r_cnt, 0);
    tick;
    check("clr_cnt_hold", l_cnt, 0);

    // Reset with two sets in flight, then a set right after reset
    drive(1'b1, 4'b1111, 20'b0, 5'b11111);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mid_rst_valid", l_ov, 0);
    check("mid_rst_alloc", l_alloc, 0);
    check("mid_rst_ptr", u_rr.rr_ptr, 0);
    check("mid_rst_cnt", r_cnt, 0);
    drive(1'b1, 4'b1111, pv(5'b01000, 5'b00100, 5'b00010, 5'b00001), 5'b11111);
    tick;
    in_valid = 1'b0;
    check("mid_rst_valid2", r_ov, 0);
    tick;
    check("post_rst_valid", l_ov, 1);
    check("post_rst_alloc", l_alloc, pv(5'b01000, 5'b00100, 5'b00010, 5'b00001));
    check("post_rst_cnt", l_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
